// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encoding,
// controller state type and the multi-step mode qualifier.
package usr_pkg;

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_LOAD = 3'b001,
      M_SHL  = 3'b010,
      M_SHR  = 3'b011,
      M_ROL  = 3'b100,
      M_ROR  = 3'b101,
      M_ASR  = 3'b110,
      M_CLR  = 3'b111
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Only the shift and rotate operations make sense repeated over several cycles.
   function automatic logic is_multi_mode(input logic [2:0] m);
      return (m >= 3'(M_SHL)) && (m <= 3'(M_ASR));
   endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One-step next-value logic for the universal shift register; shared by the
// single-step path and the multi-step RUN path.
module usr_shift_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] Q,
   input  logic [WIDTH-1:0] D,
   input  logic             ser_in,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] next_q
);

   always_comb begin
      next_q = Q;
      case (mode_t'(mode))
         M_HOLD:  next_q = Q;
         M_LOAD:  next_q = D;
         M_SHL:   next_q = {Q[WIDTH-2:0], ser_in};
         M_SHR:   next_q = {ser_in, Q[WIDTH-1:1]};
         M_ROL:   next_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
         M_ROR:   next_q = {Q[0], Q[WIDTH-1:1]};
         M_ASR:   next_q = {Q[WIDTH-1], Q[WIDTH-1:1]};
         M_CLR:   next_q = '0;
         default: next_q = Q;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-step commands and a multi-step
// shift/rotate sequencer (IDLE -> RUN -> DONE) that pulses done on completion.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             ser_in,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] Q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [2:0]       run_mode;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       step_mode;
   logic [WIDTH-1:0] step_q;

   // While running, the latched mode owns both the datapath and ser_out.
   assign step_mode = (state == S_RUN) ? run_mode : mode;
   assign ser_out   = (step_mode == 3'(M_SHL) || step_mode == 3'(M_ROL)) ? Q[WIDTH-1] : Q[0];

   usr_shift_step #(.WIDTH(WIDTH)) u_step (
      .Q      (Q),
      .D      (D),
      .ser_in (ser_in),
      .mode   (step_mode),
      .next_q (step_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         Q        <= '0;
         run_mode <= 3'(M_HOLD);
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               Q   <= step_q;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               // A start with a non-shift mode is not a command, so enable still applies.
               if (start && is_multi_mode(mode)) begin
                  run_mode <= mode;
                  if (amount == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     cnt   <= amount;
                  end
               end else if (enable) begin
                  Q <= step_q;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): per-cycle comparison
// against an arithmetic reference model plus directed literal expectations.
module tb_universal_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable, start, ser_in;
   logic [2:0]    mode;
   logic [W-1:0]  D;
   logic [CW-1:0] amount;
   logic [W-1:0]  Q;
   logic          ser_out, busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   universal_shift_reg #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .mode    (mode),
      .D       (D),
      .ser_in  (ser_in),
      .start   (start),
      .amount  (amount),
      .Q       (Q),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one operation expressed as integer arithmetic on the register value.
   function automatic logic [W-1:0] ref_step(input logic [W-1:0] q, input logic [2:0] m,
                                             input logic [W-1:0] d, input logic s);
      int v    = int'(q);
      int mask = (1 << W) - 1;
      int msb  = 1 << (W - 1);
      case (m)
         3'd0:    return q;
         3'd1:    return d;
         3'd2:    return W'(((v << 1) | int'(s)) & mask);
         3'd3:    return W'((v >> 1) | (int'(s) * msb));
         3'd4:    return W'(((v << 1) | (v >> (W - 1))) & mask);
         3'd5:    return W'((v >> 1) | ((v & 1) * msb));
         3'd6:    return W'((v >> 1) | (v & msb));
         default: return '0;
      endcase
   endfunction

   logic [W-1:0] mq    = '0;
   logic [2:0]   mmode = 3'd0;
   int           mrem  = 0;
   bit           mbusy = 1'b0;
   bit           mdone = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq = '0; mrem = 0; mbusy = 1'b0; mdone = 1'b0;
      end else if (mbusy) begin
         mq = ref_step(mq, mmode, '0, ser_in);
         mrem = mrem - 1;
         if (mrem == 0) begin
            mbusy = 1'b0;
            mdone = 1'b1;
         end
      end else begin
         mdone = 1'b0;
         if (start && mode >= 3'd2 && mode <= 3'd6) begin
            mmode = mode;
            if (amount == 0) mdone = 1'b1;
            else begin
               mbusy = 1'b1;
               mrem  = int'(amount);
            end
         end else if (enable) begin
            mq = ref_step(mq, mode, D, ser_in);
         end
      end
   end

   always @(negedge clk) begin
      logic [2:0] eff;
      eff = mbusy ? mmode : mode;
      chk("model_q", Q, mq);
      chk("model_busy", busy, mbusy);
      chk("model_done", done, mdone);
      chk("model_ser_out", ser_out, (eff == 3'd2 || eff == 3'd4) ? mq[W-1] : mq[0]);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [W-1:0] v);
      enable = 1'b1; mode = 3'd1; D = v;
      cyc();
      enable = 1'b0; mode = 3'd0; D = '0;
   endtask

   initial begin
      enable = 0; start = 0; mode = 0; D = 0; ser_in = 0; amount = 0;
      #1 reset = 1'b1;
      #1;
      chk("reset_q", Q, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      @(posedge clk); #1 reset = 1'b0;

      // parallel load then hold
      enable = 1; mode = 3'd1; D = 8'hA5;
      cyc();
      enable = 0; mode = 3'd0; D = 8'h00;
      chk("load_a5", Q, 8'hA5);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_a5", Q, 8'hA5);
      end

      // ROL by 3 from 0x81
      load(8'h81);
      start = 1; mode = 3'd4; amount = 3;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      chk("rol_busy0", busy, 1'b1);
      chk("rol_q0", Q, 8'h81);
      cyc(); chk("rol_q1", Q, 8'h03); chk("rol_busy1", busy, 1'b1); chk("rol_serout", ser_out, 1'b0);
      cyc(); chk("rol_q2", Q, 8'h06); chk("rol_busy2", busy, 1'b1);
      cyc(); chk("rol_q3", Q, 8'h0C); chk("rol_busy3", busy, 1'b0); chk("rol_done", done, 1'b1);
      cyc(); chk("rol_done_end", done, 1'b0);

      // ASR then SHR single steps
      load(8'h80);
      enable = 1; mode = 3'd6;
      cyc(); chk("asr", Q, 8'hC0);
      mode = 3'd3; ser_in = 0;
      cyc(); chk("shr", Q, 8'h60);
      enable = 0; mode = 3'd0;

      // reset during RUN
      load(8'hFF);
      start = 1; mode = 3'd2; amount = 4; ser_in = 0;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      cyc(); chk("shl_run_q", Q, 8'hFE); chk("shl_run_busy", busy, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("midrun_reset_q", Q, 8'h00);
      chk("midrun_reset_busy", busy, 1'b0);
      chk("midrun_reset_done", done, 1'b0);
      #1 reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("no_done_after_reset", done, 1'b0);
         chk("q_after_reset", Q, 8'h00);
      end

      // zero amount goes straight to DONE
      load(8'h3C);
      start = 1; mode = 3'd5; amount = 0;
      cyc();
      start = 0; mode = 3'd0;
      chk("amt0_q", Q, 8'h3C); chk("amt0_busy", busy, 1'b0); chk("amt0_done", done, 1'b1);
      cyc(); chk("amt0_done_end", done, 1'b0); chk("amt0_q_end", Q, 8'h3C);

      // rotate by more than WIDTH wraps
      load(8'h96);
      start = 1; mode = 3'd5; amount = 9;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      cyc(9); chk("ror9_q", Q, 8'h4B); chk("ror9_done", done, 1'b1);

      // shift by more than WIDTH fills completely
      load(8'h00);
      start = 1; mode = 3'd2; amount = 10; ser_in = 1;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      cyc(10); chk("shl10_q", Q, 8'hFF); chk("shl10_done", done, 1'b1);
      ser_in = 0;

      // ser_in sampled fresh each RUN cycle
      load(8'h00);
      start = 1; mode = 3'd3; amount = 4;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      ser_in = 1; cyc();
      ser_in = 0; cyc();
      ser_in = 1; cyc();
      ser_in = 1; cyc();
      ser_in = 0;
      chk("shr_serial_q", Q, 8'hD0); chk("shr_serial_done", done, 1'b1);

      // start with a non-shift mode is ignored
      cyc();
      load(8'h55);
      start = 1; mode = 3'd1; D = 8'hFF; amount = 2;
      cyc();
      start = 0; mode = 3'd0; D = 8'h00; amount = 0;
      chk("bad_start_q", Q, 8'h55); chk("bad_start_busy", busy, 1'b0); chk("bad_start_done", done, 1'b0);
      cyc(); chk("bad_start_done2", done, 1'b0);

      // start wins over enable
      load(8'h0F);
      start = 1; enable = 1; mode = 3'd3; amount = 2; ser_in = 0;
      cyc();
      start = 0; enable = 0; mode = 3'd0; amount = 0;
      chk("prio_busy", busy, 1'b1); chk("prio_q", Q, 8'h0F);
      cyc(2); chk("prio_q_end", Q, 8'h03); chk("prio_done", done, 1'b1);

      // new command accepted from DONE
      start = 1; mode = 3'd4; amount = 1;
      cyc();
      start = 0; mode = 3'd0; amount = 0;
      chk("b2b_busy", busy, 1'b1); chk("b2b_done", done, 1'b0);
      cyc(); chk("b2b_q", Q, 8'h06); chk("b2b_done2", done, 1'b1);

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
